// File: rtl/arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0]  OWNER_NONE = 2'b00;
  localparam logic [1:0]  OWNER_M0   = 2'b01;
  localparam logic [1:0]  OWNER_M1   = 2'b10;

  // Returned to a master whose transaction was aborted by the stall timeout.
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  // Owner code reported for a given arbiter state.
  function automatic logic [1:0] owner_of(arb_state_t s);
    case (s)
      OWN0:    owner_of = OWNER_M0;
      OWN1:    owner_of = OWNER_M1;
      default: owner_of = OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for two requesters (round-robin or fixed priority).
module arb_pick #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,      // 0 favours requester 0, 1 favours requester 1
  output logic gnt0_c_o,
  output logic gnt1_c_o
);

  // Single requester wins outright; a tie goes by priority mode and pointer.
  always_comb begin
    gnt0_c_o = 1'b0;
    gnt1_c_o = 1'b0;
    if (req0_i && req1_i) begin
      if (FIXED_PRIO || !ptr_i) begin
        gnt0_c_o = 1'b1;
      end else begin
        gnt1_c_o = 1'b1;
      end
    end else begin
      gnt0_c_o = req0_i;
      gnt1_c_o = req1_i;
    end
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter: serialises whole waitrequest-style transactions
// onto one slave port, with optional stall timeout abort.
module avalon_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  // master 0 (CPU)
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  // master 1 (loader / debug)
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  // slave
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  // status
  output logic [1:0]            owner,
  output logic                  timeout_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT != 0);

  arb_state_t        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              terr_q, terr_d;
  logic [1:0]        owner_q;

  logic              req0_c, req1_c;
  logic              gnt0_c, gnt1_c;

  logic [ADDR_W-1:0] sel_address_c;
  logic              sel_read_c, sel_write_c, sel_req_c;
  logic [DATA_W-1:0] sel_writedata_c;
  logic [BE_W-1:0]   sel_byteenable_c;

  logic              own_wait_c;
  logic [DATA_W-1:0] own_rdata_c;

  assign req0_c = m0_read | m0_write;
  assign req1_c = m1_read | m1_write;

  arb_pick #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .req0_i   (req0_c),
    .req1_i   (req1_c),
    .ptr_i    (ptr_q),
    .gnt0_c_o (gnt0_c),
    .gnt1_c_o (gnt1_c)
  );

  // Select the command fields of whichever master owns the bus.
  always_comb begin
    sel_address_c    = m0_address;
    sel_read_c       = m0_read;
    sel_write_c      = m0_write;
    sel_writedata_c  = m0_writedata;
    sel_byteenable_c = m0_byteenable;
    sel_req_c        = req0_c;
    if (state_q == OWN1) begin
      sel_address_c    = m1_address;
      sel_read_c       = m1_read;
      sel_write_c      = m1_write;
      sel_writedata_c  = m1_writedata;
      sel_byteenable_c = m1_byteenable;
      sel_req_c        = req1_c;
    end
  end

  // Next-state, pointer, timeout and slave-command logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = '0;
    terr_d       = terr_q;
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    own_wait_c   = 1'b1;
    own_rdata_c  = '0;
    case (state_q)
      IDLE: begin
        if (gnt0_c) begin
          state_d = OWN0;
        end else if (gnt1_c) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        s_address    = sel_address_c;
        s_writedata  = sel_writedata_c;
        s_byteenable = sel_byteenable_c;
        s_write      = sel_write_c;
        s_read       = sel_read_c & ~sel_write_c;
        own_wait_c   = s_waitrequest;
        own_rdata_c  = s_readdata;
        if (!sel_req_c) begin
          // owner abandoned a stalled transaction; pointer left alone
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
          ptr_d   = (state_q == OWN0);
        end else if (TO_EN && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          own_wait_c  = 1'b0;
          own_rdata_c = DATA_W'(ABORT_DATA);
          terr_d      = 1'b1;
          state_d     = IDLE;
          ptr_d       = (state_q == OWN0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route the response to the owner; the other master stays stalled.
  always_comb begin
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    if (state_q == OWN0) begin
      m0_waitrequest = own_wait_c;
      m0_readdata    = own_rdata_c;
    end
    if (state_q == OWN1) begin
      m1_waitrequest = own_wait_c;
      m1_readdata    = own_rdata_c;
    end
  end

  // State, pointer, counter and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      owner_q <= OWNER_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      owner_q <= owner_of(state_d);
    end
  end

  assign owner       = owner_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed self-checking bench for avalon_bus_arbiter (round-robin and fixed-priority instances).
module tb_avalon_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;

  // round-robin instance outputs
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic [1:0]  owner;
  logic        timeout_err;

  // fixed-priority instance outputs
  logic        f_m0_waitrequest, f_m1_waitrequest;
  logic [31:0] f_m0_readdata, f_m1_readdata;
  logic [31:0] f_s_address, f_s_writedata;
  logic        f_s_read, f_s_write;
  logic [3:0]  f_s_byteenable;
  logic [1:0]  f_owner;
  logic        f_timeout_err;

  int checks = 0;
  int errors = 0;

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .owner(owner), .timeout_err(timeout_err)
  );

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(8)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(f_m0_waitrequest), .m0_readdata(f_m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(f_m1_waitrequest), .m1_readdata(f_m1_readdata),
    .s_address(f_s_address), .s_read(f_s_read), .s_write(f_s_write),
    .s_writedata(f_s_writedata), .s_byteenable(f_s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .owner(f_owner), .timeout_err(f_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 0; s_readdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    tick();
    tick();
    #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rst_owner got %h exp %h", owner, 2'b00); end
    checks++; if ({s_read, s_write} !== 2'b00) begin errors++; $display("FAIL rst_cmd got %b exp %b", {s_read, s_write}, 2'b00); end
    checks++; if (s_address !== 32'h0 || s_writedata !== 32'h0 || s_byteenable !== 4'h0) begin errors++; $display("FAIL rst_sbus got %h/%h/%h exp 0/0/0", s_address, s_writedata, s_byteenable); end
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL rst_wait got %b exp %b", {m0_waitrequest, m1_waitrequest}, 2'b11); end
    checks++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", m0_readdata, m1_readdata); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr got %b exp 0", timeout_err); end
    reset = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_read = 1; m0_address = 32'h0000_1000; s_waitrequest = 1; #1;
    checks++; if (s_read !== 1'b0 || owner !== 2'b00) begin errors++; $display("FAIL t1_idle got rd=%b own=%h exp rd=0 own=0", s_read, owner); end
    tick(); #1;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL t1_owner got %h exp %h", owner, 2'b01); end
    checks++; if (s_read !== 1'b1 || s_address !== 32'h0000_1000) begin errors++; $display("FAIL t1_fwd got rd=%b a=%h exp rd=1 a=00001000", s_read, s_address); end
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL t1_stall2 got %b exp 11", {m0_waitrequest, m1_waitrequest}); end
    tick(); #1;
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL t1_stall3 got %b exp 1", m0_waitrequest); end
    tick();
    s_waitrequest = 0; s_readdata = 32'h1234_5678; #1;
    checks++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'h1234_5678) begin errors++; $display("FAIL t1_done got w=%b d=%h exp w=0 d=12345678", m0_waitrequest, m0_readdata); end
    checks++; if (m1_waitrequest !== 1'b1 || m1_readdata !== 32'h0) begin errors++; $display("FAIL t1_m1 got w=%b d=%h exp w=1 d=0", m1_waitrequest, m1_readdata); end
    tick();
    m0_read = 0; s_waitrequest = 1; #1;
    checks++; if (owner !== 2'b00 || s_read !== 1'b0) begin errors++; $display("FAIL t1_back got own=%h rd=%b exp own=0 rd=0", owner, s_read); end
    clear_inputs();
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    m0_write = 1; m0_address = 32'hA000_0000; m0_writedata = 32'h1111_1111; m0_byteenable = 4'hF;
    m1_write = 1; m1_address = 32'hB000_0000; m1_writedata = 32'h2222_2222; m1_byteenable = 4'hF;
    s_waitrequest = 0; #1;
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL t2_idle got %b exp 0", s_write); end
    tick(); #1;
    checks++; if (owner !== 2'b01 || s_address !== 32'hA000_0000 || s_writedata !== 32'h1111_1111) begin errors++; $display("FAIL t2_first got own=%h a=%h d=%h exp 01/A0000000/11111111", owner, s_address, s_writedata); end
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL t2_first_w got %b exp 01", {m0_waitrequest, m1_waitrequest}); end
    tick();
    m0_writedata = 32'h3333_3333; #1;
    checks++; if (owner !== 2'b00 || s_write !== 1'b0) begin errors++; $display("FAIL t2_gap got own=%h wr=%b exp 00/0", owner, s_write); end
    tick(); #1;
    checks++; if (owner !== 2'b10 || s_address !== 32'hB000_0000 || s_writedata !== 32'h2222_2222) begin errors++; $display("FAIL t2_second got own=%h a=%h d=%h exp 10/B0000000/22222222", owner, s_address, s_writedata); end
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin errors++; $display("FAIL t2_second_w got %b exp 10", {m0_waitrequest, m1_waitrequest}); end
    tick(); #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL t2_gap2 got %h exp 00", owner); end
    tick(); #1;
    checks++; if (owner !== 2'b01 || s_writedata !== 32'h3333_3333) begin errors++; $display("FAIL t2_third got own=%h d=%h exp 01/33333333", owner, s_writedata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    m0_read = 1; m0_address = 32'h10; m1_read = 1; m1_address = 32'h20; s_waitrequest = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (f_owner !== 2'b01 || f_m1_waitrequest !== 1'b1) begin errors++; $display("FAIL t3_grant%0d got own=%h w1=%b exp 01/1", i, f_owner, f_m1_waitrequest); end
      tick(); #1;
      checks++; if (f_owner !== 2'b00) begin errors++; $display("FAIL t3_gap%0d got %h exp 00", i, f_owner); end
    end
    m0_read = 0;
    tick(); #1;
    checks++; if (f_owner !== 2'b10 || f_m1_waitrequest !== 1'b0 || f_s_address !== 32'h20) begin errors++; $display("FAIL t3_m1 got own=%h w1=%b a=%h exp 10/0/20", f_owner, f_m1_waitrequest, f_s_address); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    m1_read = 1; m1_address = 32'h40; s_waitrequest = 1;
    tick();
    for (int c = 1; c < 8; c++) begin
      #1;
      checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL t4_stall%0d got %b exp 1", c, m1_waitrequest); end
      tick();
    end
    #1;
    checks++; if (m1_waitrequest !== 1'b0 || m1_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t4_abort got w=%b d=%h exp 0/deadbeef", m1_waitrequest, m1_readdata); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t4_terr_early got %b exp 0", timeout_err); end
    tick();
    m1_read = 0; #1;
    checks++; if (owner !== 2'b00 || timeout_err !== 1'b1) begin errors++; $display("FAIL t4_after got own=%h te=%b exp 00/1", owner, timeout_err); end
    m0_read = 1; s_waitrequest = 0; s_readdata = 32'h55AA_55AA;
    tick(); #1;
    checks++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'h55AA_55AA || timeout_err !== 1'b1) begin errors++; $display("FAIL t4_next got w=%b d=%h te=%b exp 0/55aa55aa/1", m0_waitrequest, m0_readdata, timeout_err); end
    tick();
    clear_inputs(); #1;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL t4_sticky got %b exp 1", timeout_err); end
    do_reset(); #1;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t4_clear got %b exp 0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_write = 1; s_waitrequest = 0;
    tick(); #1;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL t5_pre got %h exp 01", owner); end
    tick();
    m0_write = 0; m1_write = 1; m1_address = 32'h80; m1_writedata = 32'hABCD_0001; s_waitrequest = 1;
    tick(); #1;
    checks++; if (owner !== 2'b10 || s_write !== 1'b1) begin errors++; $display("FAIL t5_own1 got own=%h wr=%b exp 10/1", owner, s_write); end
    reset = 1; m0_write = 1;
    tick(); #1;
    checks++; if (s_write !== 1'b0 || owner !== 2'b00) begin errors++; $display("FAIL t5_drop got wr=%b own=%h exp 0/00", s_write, owner); end
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL t5_wait got %b exp 11", {m0_waitrequest, m1_waitrequest}); end
    reset = 0;
    tick(); #1;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL t5_regrant got %h exp 01", owner); end
    tick();
    clear_inputs();
  endtask

  task automatic test_read_write_both();
    do_reset();
    m1_read = 1; m1_write = 1; m1_byteenable = 4'b0011;
    m1_address = 32'h0000_0C00; m1_writedata = 32'hCAFE_F00D; s_waitrequest = 0;
    tick(); #1;
    checks++; if ({s_write, s_read} !== 2'b10) begin errors++; $display("FAIL t6_cmd got %b exp 10", {s_write, s_read}); end
    checks++; if (s_byteenable !== 4'b0011) begin errors++; $display("FAIL t6_be got %b exp 0011", s_byteenable); end
    checks++; if (s_writedata !== 32'hCAFE_F00D || s_address !== 32'h0000_0C00) begin errors++; $display("FAIL t6_data got d=%h a=%h exp cafef00d/00000c00", s_writedata, s_address); end
    tick();
    clear_inputs();
  endtask

  initial begin
    clk = 0;
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie_round_robin();
    test_fixed_prio();
    test_timeout();
    test_reset_mid();
    test_read_write_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
